// File: rtl/spi_slave_rdid_pkg.sv
// Shared definitions for the SPI RDID/RDSR responder.
// Holds opcodes, FSM state encodings, default JEDEC ID constants and the response payload type.
package spi_defs;

   localparam int unsigned CMD_W  = 8;
   localparam int unsigned RESP_W = 24;
   localparam int unsigned CNT_W  = 5;

   localparam logic [7:0] CMD_RDID = 8'h9F;
   localparam logic [7:0] CMD_RDSR = 8'h05;

   localparam logic [7:0] DEF_ID_BYTE0 = 8'h20;
   localparam logic [7:0] DEF_ID_BYTE1 = 8'h20;
   localparam logic [7:0] DEF_ID_BYTE2 = 8'h15;
   localparam logic [7:0] DEF_STATUS   = 8'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CMD    = 2'd1,
      RESP   = 2'd2,
      IGNORE = 2'd3
   } state_e;

   // Three response bytes, b0 goes out first on the wire
   typedef struct packed {
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
   } resp_t;

endpackage

// File: rtl/spi_slave_rdid_if.sv
// SPI bus between master and the RDID responder, including the slave output enable.
interface spi_slave_rdid_if;
   logic SPICLK;
   logic SPIMOSI;
   logic SPICS_N;
   logic SPIMISO;
   logic miso_oe;

   modport master (output SPICLK, output SPIMOSI, output SPICS_N,
                   input SPIMISO, input miso_oe);
   modport slave  (input SPICLK, input SPIMOSI, input SPICS_N,
                   output SPIMISO, output miso_oe);
endinterface

// File: rtl/spi_slave_rdid_sync_edge.sv
// Two-flop synchronizer, and a variant adding a one-clk rise/fall strobe behind it.
module spi_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;
endmodule

module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise_c,
   output logic fall_c
);
   logic sync;
   logic prev_q, prev_d;

   spi_sync2 #(.RST_VAL(RST_VAL)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (d),
      .q     (sync)
   );

   always_comb prev_d = sync;

   always_ff @(posedge clk) begin
      if (!reset) prev_q <= RST_VAL;
      else        prev_q <= prev_d;
   end

   assign rise_c = sync & ~prev_q;
   assign fall_c = ~sync & prev_q;
endmodule

// File: rtl/spi_slave_rdid.sv
// SPI mode-0 responder: decodes one command byte, answers RDID with a JEDEC ID and RDSR with status.
// All SPI pins are oversampled in the clk domain; decisions are made on synchronized edge strobes.
module spi_slave_rdid
   import spi_defs::*;
#(
   parameter logic [7:0] ID_BYTE0 = DEF_ID_BYTE0,
   parameter logic [7:0] ID_BYTE1 = DEF_ID_BYTE1,
   parameter logic [7:0] ID_BYTE2 = DEF_ID_BYTE2,
   parameter logic [7:0] STATUS   = DEF_STATUS
) (
   input  logic                 clk,
   input  logic                 reset,
   spi_slave_rdid_if.slave      spi,
   output logic                 cmd_valid,
   output logic [CMD_W-1:0]     cmd_byte
);
   localparam resp_t ID_WORD = '{b0: ID_BYTE0, b1: ID_BYTE1, b2: ID_BYTE2};
   localparam resp_t SR_WORD = '{b0: STATUS, b1: STATUS, b2: STATUS};

   logic clk_rise, clk_fall, mosi_s, cs_s;

   spi_sync_edge #(.RST_VAL(1'b0)) u_clk_edge (
      .clk    (clk),
      .reset  (reset),
      .d      (spi.SPICLK),
      .rise_c (clk_rise),
      .fall_c (clk_fall)
   );

   spi_sync2 #(.RST_VAL(1'b0)) u_mosi_sync (
      .clk   (clk),
      .reset (reset),
      .d     (spi.SPIMOSI),
      .q     (mosi_s)
   );

   spi_sync2 #(.RST_VAL(1'b1)) u_cs_sync (
      .clk   (clk),
      .reset (reset),
      .d     (spi.SPICS_N),
      .q     (cs_s)
   );

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CMD_W-2:0]    cmd_sr_q, cmd_sr_d;
   logic [RESP_W-1:0]   resp_sr_q, resp_sr_d;
   logic                miso_q, miso_d;
   logic                oe_q, oe_d;
   logic                cmd_valid_q, cmd_valid_d;
   logic [CMD_W-1:0]    cmd_byte_q, cmd_byte_d;
   logic [CMD_W-1:0]    cmd_shift;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cmd_sr_q    <= '0;
         resp_sr_q   <= '0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_byte_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_sr_q    <= cmd_sr_d;
         resp_sr_q   <= resp_sr_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_byte_q  <= cmd_byte_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_sr_d    = cmd_sr_q;
      resp_sr_d   = resp_sr_q;
      miso_d      = miso_q;
      oe_d        = oe_q;
      cmd_valid_d = 1'b0;
      cmd_byte_d  = cmd_byte_q;
      cmd_shift   = {cmd_sr_q, mosi_s};

      // Deselect wins over any edge seen in the same cycle
      if (cs_s) begin
         state_d = IDLE;
         cnt_d   = '0;
         oe_d    = 1'b0;
         miso_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (clk_rise) begin
                  cmd_sr_d = cmd_shift[CMD_W-2:0];
                  cnt_d    = CNT_W'(1);
                  state_d  = CMD;
               end
            end
            CMD: begin
               if (clk_rise) begin
                  if (cnt_q == CNT_W'(CMD_W - 1)) begin
                     cmd_byte_d  = cmd_shift;
                     cmd_valid_d = 1'b1;
                     cnt_d       = '0;
                     if (cmd_shift == CMD_RDID) begin
                        resp_sr_d = ID_WORD;
                        state_d   = RESP;
                     end else if (cmd_shift == CMD_RDSR) begin
                        resp_sr_d = SR_WORD;
                        state_d   = RESP;
                     end else begin
                        state_d   = IGNORE;
                     end
                  end else begin
                     cmd_sr_d = cmd_shift[CMD_W-2:0];
                     cnt_d    = cnt_q + CNT_W'(1);
                  end
               end
            end
            RESP: begin
               // A rise in the same cycle takes priority and holds MISO
               if (clk_fall && !clk_rise) begin
                  if (cmd_byte_q == CMD_RDSR) begin
                     // Rotating three status copies reloads the byte every 8 bits
                     miso_d    = resp_sr_q[RESP_W-1];
                     oe_d      = 1'b1;
                     resp_sr_d = {resp_sr_q[RESP_W-2:0], resp_sr_q[RESP_W-1]};
                  end else if (cnt_q < CNT_W'(RESP_W)) begin
                     miso_d    = resp_sr_q[RESP_W-1];
                     oe_d      = 1'b1;
                     resp_sr_d = {resp_sr_q[RESP_W-2:0], 1'b0};
                     cnt_d     = cnt_q + CNT_W'(1);
                  end else begin
                     miso_d = 1'b0;
                     oe_d   = 1'b0;
                  end
               end
            end
            IGNORE: begin
               miso_d = 1'b0;
               oe_d   = 1'b0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign spi.SPIMISO = miso_q;
   assign spi.miso_oe = oe_q;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_byte    = cmd_byte_q;
endmodule

// File: tb/tb_spi_slave_rdid.sv
// Directed bench for spi_slave_rdid: RDID, RDSR (default and 0xA5 status), unknown command,
// CS abort mid-response, and CS-tied-low operation.
module tb_spi_slave_rdid;
   import spi_defs::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       sclk, mosi, cs_n;
   logic       cmd_valid, cmd_valid2;
   logic [7:0] cmd_byte, cmd_byte2;

   spi_slave_rdid_if bus ();
   spi_slave_rdid_if bus2 ();

   assign bus.SPICLK   = sclk;
   assign bus.SPIMOSI  = mosi;
   assign bus.SPICS_N  = cs_n;
   assign bus2.SPICLK  = sclk;
   assign bus2.SPIMOSI = mosi;
   assign bus2.SPICS_N = cs_n;

   spi_slave_rdid dut (
      .clk       (clk),
      .reset     (reset),
      .spi       (bus),
      .cmd_valid (cmd_valid),
      .cmd_byte  (cmd_byte)
   );

   spi_slave_rdid #(.STATUS(8'hA5)) dut_a5 (
      .clk       (clk),
      .reset     (reset),
      .spi       (bus2),
      .cmd_valid (cmd_valid2),
      .cmd_byte  (cmd_byte2)
   );

   int  total, bad;
   int  vcnt;
   int  vexp;
   time vtime, last_rise, cmd_rise;

   // Count cmd_valid high cycles and remember when the latest one was seen
   always @(negedge clk) begin
      if (cmd_valid) begin
         vcnt  = vcnt + 1;
         vtime = $time;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      if (obs !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Mode-0 master at clk/4: MOSI set in low phase, MISO sampled at end of high phase
   task automatic spi_bits(input logic [31:0] tx, input int n,
                           output logic [31:0] rx, output logic [31:0] rx2,
                           output logic oe_and, output logic oe_or);
      logic [31:0] r, r2;
      logic a, o;
      r = '0; r2 = '0; a = 1'b1; o = 1'b0;
      for (int i = 0; i < n; i++) begin
         mosi = tx[n-1-i];
         repeat (2) @(negedge clk);
         sclk = 1'b1;
         last_rise = $time;
         repeat (2) @(negedge clk);
         r  = {r[30:0], bus.SPIMISO};
         r2 = {r2[30:0], bus2.SPIMISO};
         a  = a & bus.miso_oe;
         o  = o | bus.miso_oe;
         sclk = 1'b0;
      end
      rx = r; rx2 = r2; oe_and = a; oe_or = o;
   endtask

   task automatic cs_gap();
      cs_n = 1'b1;
      repeat (5) @(negedge clk);
      cs_n = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   logic [31:0] rx, rx2;
   logic        oe_and, oe_or;

   initial begin
      total = 0; bad = 0; vcnt = 0; vexp = 0;
      vtime = 0; last_rise = 0; cmd_rise = 0;
      reset = 1'b0; sclk = 1'b0; mosi = 1'b1; cs_n = 1'b0;

      // Reset held with SPICLK toggling
      repeat (10) @(negedge clk) sclk = ~sclk;
      chk("rst_miso", 32'(bus.SPIMISO), 32'd0);
      chk("rst_oe", 32'(bus.miso_oe), 32'd0);
      chk("rst_vcnt", 32'(vcnt), 32'd0);
      chk("rst_cmd_byte", 32'(cmd_byte), 32'h00);
      sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
      @(negedge clk) reset = 1'b1;
      repeat (4) @(negedge clk);

      // RDID full response
      cs_n = 1'b0;
      repeat (3) @(negedge clk);
      spi_bits(32'(CMD_RDID), 8, rx, rx2, oe_and, oe_or);
      cmd_rise = last_rise;
      chk("rdid_cmd_oe", 32'(oe_or), 32'd0);
      spi_bits(32'd0, 24, rx, rx2, oe_and, oe_or);
      vexp = vexp + 1;
      chk("rdid_vcnt", 32'(vcnt), 32'(vexp));
      chk("rdid_valid_lat", 32'(vtime - cmd_rise), 32'd30);
      chk("rdid_cmd_byte", 32'(cmd_byte), 32'h9F);
      chk("rdid_id", rx, 32'h00202015);
      chk("rdid_oe_on", 32'(oe_and), 32'd1);
      repeat (4) @(negedge clk);
      chk("rdid_oe_off", 32'(bus.miso_oe), 32'd0);
      chk("rdid_miso_off", 32'(bus.SPIMISO), 32'd0);
      spi_bits(32'd0, 4, rx, rx2, oe_and, oe_or);
      chk("rdid_tail_oe", 32'(oe_or), 32'd0);
      chk("rdid_tail_miso", rx, 32'd0);

      // RDSR on both instances, crossing the 24-bit boundary
      cs_gap();
      spi_bits(32'(CMD_RDSR), 8, rx, rx2, oe_and, oe_or);
      spi_bits(32'd0, 16, rx, rx2, oe_and, oe_or);
      vexp = vexp + 1;
      chk("rdsr_cmd_byte", 32'(cmd_byte), 32'h05);
      chk("rdsr_def", rx, 32'h0000);
      chk("rdsr_a5", rx2, 32'hA5A5);
      chk("rdsr_oe", 32'(oe_and), 32'd1);
      spi_bits(32'd0, 16, rx, rx2, oe_and, oe_or);
      chk("rdsr_a5_repeat", rx2, 32'hA5A5);
      chk("rdsr_a5_cmd", 32'(cmd_byte2), 32'h05);

      // Unknown command is ignored, then RDID works after CS toggle
      cs_gap();
      spi_bits(32'h03, 8, rx, rx2, oe_and, oe_or);
      spi_bits(32'hFF, 8, rx, rx2, oe_and, oe_or);
      vexp = vexp + 1;
      chk("ign_cmd_byte", 32'(cmd_byte), 32'h03);
      chk("ign_oe", 32'(oe_or), 32'd0);
      cs_gap();
      spi_bits(32'(CMD_RDID), 8, rx, rx2, oe_and, oe_or);
      spi_bits(32'd0, 24, rx, rx2, oe_and, oe_or);
      vexp = vexp + 1;
      chk("ign_then_rdid", rx, 32'h00202015);

      // CS raised after 12 response bits
      cs_gap();
      spi_bits(32'(CMD_RDID), 8, rx, rx2, oe_and, oe_or);
      spi_bits(32'd0, 12, rx, rx2, oe_and, oe_or);
      vexp = vexp + 1;
      chk("abort_part", rx, 32'h202);
      cs_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_oe", 32'(bus.miso_oe), 32'd0);
      chk("abort_miso", 32'(bus.SPIMISO), 32'd0);
      repeat (3) @(negedge clk);
      cs_n = 1'b0;
      repeat (3) @(negedge clk);
      spi_bits(32'(CMD_RDID), 8, rx, rx2, oe_and, oe_or);
      spi_bits(32'd0, 24, rx, rx2, oe_and, oe_or);
      vexp = vexp + 1;
      chk("abort_restart", rx, 32'h00202015);
      chk("abort_vcnt", 32'(vcnt), 32'(vexp));

      // CS tied low: reset starts a fresh command
      cs_n = 1'b0;
      @(negedge clk) reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("tied_rst_cmd", 32'(cmd_byte), 32'h00);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      spi_bits(32'(CMD_RDID), 8, rx, rx2, oe_and, oe_or);
      spi_bits(32'd0, 24, rx, rx2, oe_and, oe_or);
      vexp = vexp + 1;
      chk("tied_id", rx, 32'h00202015);
      chk("tied_vcnt", 32'(vcnt), 32'(vexp));
      spi_bits(32'(CMD_RDID), 8, rx, rx2, oe_and, oe_or);
      chk("tied_one_cmd", 32'(vcnt), 32'(vexp));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
